// File: rtl/tl_axi_adapter.sv
// TileLink-UH device port to AXI4 host port bridge: Get/Put bursts become AXI INCR bursts,
// R/B responses return as D-channel AccessAckData/AccessAck.
module tl_axi_adapter #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 56,
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int MaxSize     = 6,
    parameter int IdWidth     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     host_a_valid_i,
    output logic                     host_a_ready_o,
    input  logic [2:0]               host_a_opcode_i,
    input  logic [2:0]               host_a_param_i,
    input  logic [3:0]               host_a_size_i,
    input  logic [SourceWidth-1:0]   host_a_source_i,
    input  logic [AddrWidth-1:0]     host_a_address_i,
    input  logic [DataWidth/8-1:0]   host_a_mask_i,
    input  logic [DataWidth-1:0]     host_a_data_i,
    input  logic                     host_a_corrupt_i,
    output logic                     host_b_valid_o,
    input  logic                     host_b_ready_i,
    output logic [2:0]               host_b_opcode_o,
    output logic [1:0]               host_b_param_o,
    output logic [3:0]               host_b_size_o,
    output logic [SourceWidth-1:0]   host_b_source_o,
    output logic [AddrWidth-1:0]     host_b_address_o,
    output logic [DataWidth/8-1:0]   host_b_mask_o,
    output logic [DataWidth-1:0]     host_b_data_o,
    output logic                     host_b_corrupt_o,
    input  logic                     host_c_valid_i,
    output logic                     host_c_ready_o,
    input  logic [2:0]               host_c_opcode_i,
    input  logic [2:0]               host_c_param_i,
    input  logic [3:0]               host_c_size_i,
    input  logic [SourceWidth-1:0]   host_c_source_i,
    input  logic [AddrWidth-1:0]     host_c_address_i,
    input  logic [DataWidth-1:0]     host_c_data_i,
    input  logic                     host_c_corrupt_i,
    output logic                     host_d_valid_o,
    input  logic                     host_d_ready_i,
    output logic [2:0]               host_d_opcode_o,
    output logic [1:0]               host_d_param_o,
    output logic [3:0]               host_d_size_o,
    output logic [SourceWidth-1:0]   host_d_source_o,
    output logic [SinkWidth-1:0]     host_d_sink_o,
    output logic                     host_d_denied_o,
    output logic [DataWidth-1:0]     host_d_data_o,
    output logic                     host_d_corrupt_o,
    input  logic                     host_e_valid_i,
    output logic                     host_e_ready_o,
    input  logic [SinkWidth-1:0]     host_e_sink_i,
    output logic                     device_aw_valid_o,
    input  logic                     device_aw_ready_i,
    output logic [IdWidth-1:0]       device_aw_id_o,
    output logic [AddrWidth-1:0]     device_aw_addr_o,
    output logic [7:0]               device_aw_len_o,
    output logic [2:0]               device_aw_size_o,
    output logic [1:0]               device_aw_burst_o,
    output logic                     device_aw_lock_o,
    output logic [3:0]               device_aw_cache_o,
    output logic [2:0]               device_aw_prot_o,
    output logic [3:0]               device_aw_qos_o,
    output logic [3:0]               device_aw_region_o,
    output logic                     device_w_valid_o,
    input  logic                     device_w_ready_i,
    output logic [DataWidth-1:0]     device_w_data_o,
    output logic [DataWidth/8-1:0]   device_w_strb_o,
    output logic                     device_w_last_o,
    input  logic                     device_b_valid_i,
    output logic                     device_b_ready_o,
    input  logic [IdWidth-1:0]       device_b_id_i,
    input  logic [1:0]               device_b_resp_i,
    output logic                     device_ar_valid_o,
    input  logic                     device_ar_ready_i,
    output logic [IdWidth-1:0]       device_ar_id_o,
    output logic [AddrWidth-1:0]     device_ar_addr_o,
    output logic [7:0]               device_ar_len_o,
    output logic [2:0]               device_ar_size_o,
    output logic [1:0]               device_ar_burst_o,
    output logic                     device_ar_lock_o,
    output logic [3:0]               device_ar_cache_o,
    output logic [2:0]               device_ar_prot_o,
    output logic [3:0]               device_ar_qos_o,
    output logic [3:0]               device_ar_region_o,
    input  logic                     device_r_valid_i,
    output logic                     device_r_ready_o,
    input  logic [IdWidth-1:0]       device_r_id_i,
    input  logic [DataWidth-1:0]     device_r_data_i,
    input  logic [1:0]               device_r_resp_i,
    input  logic                     device_r_last_i
);

    localparam int NonBurstSize = $clog2(DataWidth / 8);
    localparam int NumSources   = 2 ** SourceWidth;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    if (IdWidth < SourceWidth) begin : gIdWidthCheck
        $error("tl_axi_adapter: IdWidth must be at least SourceWidth");
    end

    typedef enum logic {DIdle, DRBurst} dState_e;

    function automatic logic [7:0] burstLen(input logic [3:0] size);
        burstLen = 8'd0;
        if (int'(size) > NonBurstSize) begin
            burstLen = 8'((32'd1 << (int'(size) - NonBurstSize)) - 32'd1);
        end
    endfunction

    function automatic logic [2:0] beatSize(input logic [3:0] size);
        beatSize = (int'(size) > NonBurstSize) ? 3'(NonBurstSize) : size[2:0];
    endfunction

    logic                   arValid_q, awValid_q, wValid_q;
    logic [IdWidth-1:0]     arId_q, awId_q;
    logic [AddrWidth-1:0]   arAddr_q, awAddr_q;
    logic [7:0]             arLen_q, awLen_q;
    logic [2:0]             arSize_q, awSize_q;
    logic [DataWidth-1:0]   wData_q;
    logic [DataWidth/8-1:0] wStrb_q;
    logic                   wLast_q;
    logic [7:0]             putBeat_q, putBeat_d;
    logic [3:0]             rSize_q [NumSources];
    logic [3:0]             wSize_q [NumSources];

    dState_e                dState_q, dState_d;
    logic                   rLastWon_q, rLastWon_d;
    logic [7:0]             dBeat_q, dBeat_d;

    logic isGet, isPut, putFirst, arFree, awFree, wFree, getFire, putFire;
    logic [7:0] aLen;
    logic [SourceWidth-1:0] rId, bId;
    logic selR, rFire, bFire, rExpectLast;

    assign isGet    = host_a_opcode_i == OpGet;
    assign isPut    = (host_a_opcode_i == OpPutFull) || (host_a_opcode_i == OpPutPartial);
    assign putFirst = putBeat_q == 8'd0;
    assign arFree   = !arValid_q || device_ar_ready_i;
    assign awFree   = !awValid_q || device_aw_ready_i;
    assign wFree    = !wValid_q || device_w_ready_i;
    assign aLen     = burstLen(host_a_size_i);
    assign getFire  = host_a_valid_i && isGet && arFree;
    assign putFire  = host_a_valid_i && isPut && wFree && (!putFirst || awFree);

    assign host_a_ready_o = !rst_i && ((isGet && arFree) || (isPut && wFree && (!putFirst || awFree)));

    assign putBeat_d = !putFire ? putBeat_q : (putBeat_q == aLen) ? 8'd0 : putBeat_q + 8'd1;

    // Output slots: each loads on an A handshake and may drain and refill in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arValid_q <= 1'b0;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            arId_q    <= '0;
            awId_q    <= '0;
            arAddr_q  <= '0;
            awAddr_q  <= '0;
            arLen_q   <= '0;
            awLen_q   <= '0;
            arSize_q  <= '0;
            awSize_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            wLast_q   <= 1'b0;
            putBeat_q <= '0;
            for (int i = 0; i < NumSources; i++) begin
                rSize_q[i] <= '0;
                wSize_q[i] <= '0;
            end
        end else begin
            putBeat_q <= putBeat_d;
            if (getFire) begin
                arValid_q                <= 1'b1;
                arId_q                   <= IdWidth'(host_a_source_i);
                arAddr_q                 <= host_a_address_i;
                arLen_q                  <= aLen;
                arSize_q                 <= beatSize(host_a_size_i);
                rSize_q[host_a_source_i] <= host_a_size_i;
            end else if (device_ar_ready_i) begin
                arValid_q <= 1'b0;
            end
            if (putFire && putFirst) begin
                awValid_q                <= 1'b1;
                awId_q                   <= IdWidth'(host_a_source_i);
                awAddr_q                 <= host_a_address_i;
                awLen_q                  <= aLen;
                awSize_q                 <= beatSize(host_a_size_i);
                wSize_q[host_a_source_i] <= host_a_size_i;
            end else if (device_aw_ready_i) begin
                awValid_q <= 1'b0;
            end
            if (putFire) begin
                wValid_q <= 1'b1;
                wData_q  <= host_a_data_i;
                wStrb_q  <= host_a_mask_i;
                wLast_q  <= putBeat_q == aLen;
            end else if (device_w_ready_i) begin
                wValid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dState_q   <= DIdle;
            rLastWon_q <= 1'b0;
            dBeat_q    <= '0;
        end else begin
            dState_q   <= dState_d;
            rLastWon_q <= rLastWon_d;
            dBeat_q    <= dBeat_d;
        end
    end

    // D arbitration: R holds D for a whole burst; ties at a boundary go to last round's loser.
    always_comb begin
        dState_d   = dState_q;
        rLastWon_d = rLastWon_q;
        dBeat_d    = dBeat_q;
        selR       = 1'b0;
        if (dState_q == DRBurst) begin
            selR = 1'b1;
        end else if (device_r_valid_i && device_b_valid_i) begin
            selR = !rLastWon_q;
        end else begin
            selR = device_r_valid_i;
        end
        rFire = selR && device_r_valid_i && host_d_ready_i;
        bFire = !selR && device_b_valid_i && host_d_ready_i;
        if (rFire) begin
            if (device_r_last_i) begin
                dState_d   = DIdle;
                rLastWon_d = 1'b1;
                dBeat_d    = 8'd0;
            end else begin
                dState_d = DRBurst;
                dBeat_d  = dBeat_q + 8'd1;
            end
        end
        if (bFire) begin
            rLastWon_d = 1'b0;
        end
    end

    assign rId         = device_r_id_i[SourceWidth-1:0];
    assign bId         = device_b_id_i[SourceWidth-1:0];
    assign rExpectLast = dBeat_q == burstLen(rSize_q[rId]);

    assign host_d_valid_o   = !rst_i && (selR ? device_r_valid_i : device_b_valid_i);
    assign host_d_opcode_o  = selR ? OpAccessAckData : OpAccessAck;
    assign host_d_param_o   = 2'd0;
    assign host_d_size_o    = selR ? rSize_q[rId] : wSize_q[bId];
    assign host_d_source_o  = selR ? rId : bId;
    assign host_d_sink_o    = '0;
    assign host_d_denied_o  = selR ? (device_r_resp_i != 2'b00) : (device_b_resp_i != 2'b00);
    assign host_d_corrupt_o = selR && (device_r_resp_i != 2'b00);
    assign host_d_data_o    = device_r_data_i;
    assign device_r_ready_o = !rst_i && selR && host_d_ready_i;
    assign device_b_ready_o = !rst_i && !selR && host_d_ready_i;

    assign device_ar_valid_o  = arValid_q;
    assign device_ar_id_o     = arId_q;
    assign device_ar_addr_o   = arAddr_q;
    assign device_ar_len_o    = arLen_q;
    assign device_ar_size_o   = arSize_q;
    assign device_ar_burst_o  = 2'b01;
    assign device_ar_lock_o   = 1'b0;
    assign device_ar_cache_o  = 4'd0;
    assign device_ar_prot_o   = 3'd0;
    assign device_ar_qos_o    = 4'd0;
    assign device_ar_region_o = 4'd0;
    assign device_aw_valid_o  = awValid_q;
    assign device_aw_id_o     = awId_q;
    assign device_aw_addr_o   = awAddr_q;
    assign device_aw_len_o    = awLen_q;
    assign device_aw_size_o   = awSize_q;
    assign device_aw_burst_o  = 2'b01;
    assign device_aw_lock_o   = 1'b0;
    assign device_aw_cache_o  = 4'd0;
    assign device_aw_prot_o   = 3'd0;
    assign device_aw_qos_o    = 4'd0;
    assign device_aw_region_o = 4'd0;
    assign device_w_valid_o   = wValid_q;
    assign device_w_data_o    = wData_q;
    assign device_w_strb_o    = wStrb_q;
    assign device_w_last_o    = wLast_q;

    assign host_b_valid_o   = 1'b0;
    assign host_b_opcode_o  = 3'd0;
    assign host_b_param_o   = 2'd0;
    assign host_b_size_o    = 4'd0;
    assign host_b_source_o  = '0;
    assign host_b_address_o = '0;
    assign host_b_mask_o    = '0;
    assign host_b_data_o    = '0;
    assign host_b_corrupt_o = 1'b0;
    assign host_c_ready_o   = 1'b1;
    assign host_e_ready_o   = 1'b1;

    logic unusedInputs;
    assign unusedInputs = ^{host_a_param_i, host_a_corrupt_i, host_b_ready_i, host_c_valid_i,
                            host_c_opcode_i, host_c_param_i, host_c_size_i, host_c_source_i,
                            host_c_address_i, host_c_data_i, host_c_corrupt_i, host_e_valid_i,
                            host_e_sink_i, device_r_id_i, device_b_id_i};

    aLegal: assert property (@(posedge clk_i) disable iff (rst_i)
        host_a_valid_i |-> ((isGet || isPut) && (int'(host_a_size_i) <= MaxSize)));

    rLastMatch: assert property (@(posedge clk_i) disable iff (rst_i)
        rFire |-> (device_r_last_i == rExpectLast));

endmodule

// File: tb/tb_tl_axi_adapter.sv
// Directed bench for tl_axi_adapter: Get/Put conversion, D arbitration and mid-burst reset.
module tb_tl_axi_adapter;

    localparam int DW = 64;
    localparam int AW = 56;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic aValid, aReady, aCorrupt;
    logic [2:0] aOpcode, aParam;
    logic [3:0] aSize;
    logic [0:0] aSource;
    logic [AW-1:0] aAddress;
    logic [DW/8-1:0] aMask;
    logic [DW-1:0] aData;
    logic bValid, bReady, bCorrupt;
    logic [2:0] bOpcode;
    logic [1:0] bParam;
    logic [3:0] bSize;
    logic [0:0] bSource;
    logic [AW-1:0] bAddress;
    logic [DW/8-1:0] bMask;
    logic [DW-1:0] bData;
    logic cValid, cReady, cCorrupt;
    logic [2:0] cOpcode, cParam;
    logic [3:0] cSize;
    logic [0:0] cSource;
    logic [AW-1:0] cAddress;
    logic [DW-1:0] cData;
    logic dValid, dReady, dDenied, dCorrupt;
    logic [2:0] dOpcode;
    logic [1:0] dParam;
    logic [3:0] dSize;
    logic [0:0] dSource, dSink;
    logic [DW-1:0] dData;
    logic eValid, eReady;
    logic [0:0] eSink;
    logic awValid, awReady, awLock;
    logic [0:0] awId;
    logic [AW-1:0] awAddr;
    logic [7:0] awLen;
    logic [2:0] awSize, awProt;
    logic [1:0] awBurst;
    logic [3:0] awCache, awQos, awRegion;
    logic wValid, wReady, wLast;
    logic [DW-1:0] wData;
    logic [DW/8-1:0] wStrb;
    logic axBValid, axBReady;
    logic [0:0] axBId;
    logic [1:0] axBResp;
    logic arValid, arReady, arLock;
    logic [0:0] arId;
    logic [AW-1:0] arAddr;
    logic [7:0] arLen;
    logic [2:0] arSize, arProt;
    logic [1:0] arBurst;
    logic [3:0] arCache, arQos, arRegion;
    logic rValid, rReady, rLast;
    logic [0:0] rId;
    logic [DW-1:0] rData;
    logic [1:0] rResp;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    tl_axi_adapter dut (
        .clk_i(clk), .rst_i(rst),
        .host_a_valid_i(aValid), .host_a_ready_o(aReady), .host_a_opcode_i(aOpcode),
        .host_a_param_i(aParam), .host_a_size_i(aSize), .host_a_source_i(aSource),
        .host_a_address_i(aAddress), .host_a_mask_i(aMask), .host_a_data_i(aData),
        .host_a_corrupt_i(aCorrupt),
        .host_b_valid_o(bValid), .host_b_ready_i(bReady), .host_b_opcode_o(bOpcode),
        .host_b_param_o(bParam), .host_b_size_o(bSize), .host_b_source_o(bSource),
        .host_b_address_o(bAddress), .host_b_mask_o(bMask), .host_b_data_o(bData),
        .host_b_corrupt_o(bCorrupt),
        .host_c_valid_i(cValid), .host_c_ready_o(cReady), .host_c_opcode_i(cOpcode),
        .host_c_param_i(cParam), .host_c_size_i(cSize), .host_c_source_i(cSource),
        .host_c_address_i(cAddress), .host_c_data_i(cData), .host_c_corrupt_i(cCorrupt),
        .host_d_valid_o(dValid), .host_d_ready_i(dReady), .host_d_opcode_o(dOpcode),
        .host_d_param_o(dParam), .host_d_size_o(dSize), .host_d_source_o(dSource),
        .host_d_sink_o(dSink), .host_d_denied_o(dDenied), .host_d_data_o(dData),
        .host_d_corrupt_o(dCorrupt),
        .host_e_valid_i(eValid), .host_e_ready_o(eReady), .host_e_sink_i(eSink),
        .device_aw_valid_o(awValid), .device_aw_ready_i(awReady), .device_aw_id_o(awId),
        .device_aw_addr_o(awAddr), .device_aw_len_o(awLen), .device_aw_size_o(awSize),
        .device_aw_burst_o(awBurst), .device_aw_lock_o(awLock), .device_aw_cache_o(awCache),
        .device_aw_prot_o(awProt), .device_aw_qos_o(awQos), .device_aw_region_o(awRegion),
        .device_w_valid_o(wValid), .device_w_ready_i(wReady), .device_w_data_o(wData),
        .device_w_strb_o(wStrb), .device_w_last_o(wLast),
        .device_b_valid_i(axBValid), .device_b_ready_o(axBReady), .device_b_id_i(axBId),
        .device_b_resp_i(axBResp),
        .device_ar_valid_o(arValid), .device_ar_ready_i(arReady), .device_ar_id_o(arId),
        .device_ar_addr_o(arAddr), .device_ar_len_o(arLen), .device_ar_size_o(arSize),
        .device_ar_burst_o(arBurst), .device_ar_lock_o(arLock), .device_ar_cache_o(arCache),
        .device_ar_prot_o(arProt), .device_ar_qos_o(arQos), .device_ar_region_o(arRegion),
        .device_r_valid_i(rValid), .device_r_ready_o(rReady), .device_r_id_i(rId),
        .device_r_data_i(rData), .device_r_resp_i(rResp), .device_r_last_i(rLast)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one A beat at a falling edge and returns at the falling edge after the handshake.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] size,
                                 input logic [0:0] src, input logic [AW-1:0] addr,
                                 input logic [DW/8-1:0] mask, input logic [DW-1:0] data);
        bit done = 0;
        aValid = 1'b1; aOpcode = op; aSize = size; aSource = src;
        aAddress = addr; aMask = mask; aData = data;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (aReady) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        aValid = 1'b0;
        if (!done) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL %s handshake: a_ready observed 0 for 20 cycles, expected 1", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        aValid = 0; aOpcode = 0; aParam = 0; aSize = 0; aSource = 0; aAddress = 0;
        aMask = 0; aData = 0; aCorrupt = 0; bReady = 0;
        cValid = 0; cOpcode = 0; cParam = 0; cSize = 0; cSource = 0; cAddress = 0;
        cData = 0; cCorrupt = 0; dReady = 0; eValid = 0; eSink = 0;
        awReady = 0; wReady = 0; arReady = 0;
        axBValid = 0; axBId = 0; axBResp = 0;
        rValid = 0; rId = 0; rData = 0; rResp = 0; rLast = 0;

        repeat (2) @(negedge clk);
        checkOutput("reset ar_valid", arValid, 0);
        checkOutput("reset aw_valid", awValid, 0);
        checkOutput("reset w_valid", wValid, 0);
        checkOutput("reset d_valid", dValid, 0);
        checkOutput("reset b_valid", bValid, 0);
        checkOutput("reset a_ready", aReady, 0);
        checkOutput("reset r_ready", rReady, 0);
        checkOutput("reset b_ready", axBReady, 0);
        checkOutput("reset c_ready", cReady, 1);
        checkOutput("reset e_ready", eReady, 1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single-beat Get");
        applyStimulus("t1 get", OpGet, 4'd3, 1'b1, 56'h1000, 8'hFF, 64'h0);
        checkOutput("t1 ar_valid", arValid, 1);
        checkOutput("t1 ar_id", arId, 1);
        checkOutput("t1 ar_addr", arAddr, 56'h1000);
        checkOutput("t1 ar_size", arSize, 3);
        checkOutput("t1 ar_len", arLen, 0);
        checkOutput("t1 ar_burst", arBurst, 2'b01);
        arReady = 1;
        @(posedge clk); @(negedge clk);
        checkOutput("t1 ar drained", arValid, 0);
        arReady = 0;
        rValid = 1; rId = 1; rData = 64'hDEAD_BEEF_0123_4567; rResp = 0; rLast = 1; dReady = 1;
        #1;
        checkOutput("t1 d_valid", dValid, 1);
        checkOutput("t1 d_opcode", dOpcode, 1);
        checkOutput("t1 d_size", dSize, 3);
        checkOutput("t1 d_source", dSource, 1);
        checkOutput("t1 d_denied", dDenied, 0);
        checkOutput("t1 d_data", dData, 64'hDEAD_BEEF_0123_4567);
        checkOutput("t1 r_ready", rReady, 1);
        @(posedge clk); @(negedge clk);
        rValid = 0; rLast = 0;

        $display("[TB] 8-beat Get burst");
        applyStimulus("t2 get", OpGet, 4'd6, 1'b0, 56'h2000, 8'hFF, 64'h0);
        checkOutput("t2 ar_len", arLen, 7);
        checkOutput("t2 ar_size", arSize, 3);
        checkOutput("t2 ar_id", arId, 0);
        arReady = 1;
        @(posedge clk); @(negedge clk);
        arReady = 0;
        for (int i = 0; i < 8; i++) begin
            rValid = 1; rId = 0; rData = 64'h100 + 64'(i); rResp = 0; rLast = (i == 7);
            #1;
            checkOutput("t2 d_valid", dValid, 1);
            checkOutput("t2 d_source", dSource, 0);
            checkOutput("t2 d_size", dSize, 6);
            checkOutput("t2 d_data", dData, 64'h100 + 64'(i));
            @(posedge clk); @(negedge clk);
        end
        rValid = 0; rLast = 0;

        $display("[TB] PutPartialData with SLVERR");
        applyStimulus("t3 put", OpPutPartial, 4'd1, 1'b0, 56'h3002, 8'h0C, 64'h0000_0000_ABCD_0000);
        checkOutput("t3 aw_valid", awValid, 1);
        checkOutput("t3 aw_size", awSize, 1);
        checkOutput("t3 aw_len", awLen, 0);
        checkOutput("t3 aw_addr", awAddr, 56'h3002);
        checkOutput("t3 w_valid", wValid, 1);
        checkOutput("t3 w_strb", wStrb, 8'h0C);
        checkOutput("t3 w_last", wLast, 1);
        checkOutput("t3 w_data", wData, 64'h0000_0000_ABCD_0000);
        awReady = 1; wReady = 1;
        @(posedge clk); @(negedge clk);
        checkOutput("t3 aw drained", awValid, 0);
        checkOutput("t3 w drained", wValid, 0);
        awReady = 0; wReady = 0;
        axBValid = 1; axBId = 0; axBResp = 2'b10;
        #1;
        checkOutput("t3 d_valid", dValid, 1);
        checkOutput("t3 d_opcode", dOpcode, 0);
        checkOutput("t3 d_size", dSize, 1);
        checkOutput("t3 d_denied", dDenied, 1);
        checkOutput("t3 d_corrupt", dCorrupt, 0);
        checkOutput("t3 b_ready", axBReady, 1);
        @(posedge clk); @(negedge clk);
        axBValid = 0; axBResp = 0;

        $display("[TB] 4-beat PutFullData with W stall");
        aValid = 1; aOpcode = OpPutFull; aSize = 5; aSource = 1; aAddress = 56'h4000;
        aMask = 8'hFF; aData = 64'hA0; awReady = 1; wReady = 0;
        #1;
        checkOutput("t4 a_ready beat0", aReady, 1);
        @(posedge clk); @(negedge clk);
        checkOutput("t4 aw_valid", awValid, 1);
        checkOutput("t4 aw_len", awLen, 3);
        checkOutput("t4 aw_size", awSize, 3);
        checkOutput("t4 aw_id", awId, 1);
        checkOutput("t4 w_data beat0", wData, 64'hA0);
        checkOutput("t4 w_last beat0", wLast, 0);
        aData = 64'hA1;
        #1;
        checkOutput("t4 a stalled", aReady, 0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            checkOutput("t4 aw once", awValid, 0);
            checkOutput("t4 w held", wData, 64'hA0);
            checkOutput("t4 a stalled", aReady, 0);
        end
        @(posedge clk); @(negedge clk);
        wReady = 1;
        #1;
        checkOutput("t4 a resumes", aReady, 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("t4 w_valid", wValid, 1);
            checkOutput("t4 w_data", wData, 64'hA0 + 64'(i));
            checkOutput("t4 w_last", wLast, 64'(i == 3));
            checkOutput("t4 aw once", awValid, 0);
            if (i < 3) aData = 64'hA0 + 64'(i + 1);
            else aValid = 0;
        end
        @(posedge clk); @(negedge clk);
        checkOutput("t4 w drained", wValid, 0);
        wReady = 0; awReady = 0;

        $display("[TB] R burst lock and round robin with B");
        applyStimulus("t5 get", OpGet, 4'd5, 1'b0, 56'h5000, 8'hFF, 64'h0);
        checkOutput("t5 ar_len", arLen, 3);
        arReady = 1;
        @(posedge clk); @(negedge clk);
        arReady = 0;
        rValid = 1; rId = 0; rData = 64'h500; rLast = 0;
        #1;
        checkOutput("t5 beat0 opcode", dOpcode, 1);
        checkOutput("t5 beat0 size", dSize, 5);
        @(posedge clk); @(negedge clk);
        for (int i = 1; i < 4; i++) begin
            axBValid = 1; axBId = 1; axBResp = 0;
            rData = 64'h500 + 64'(i); rLast = (i == 3);
            #1;
            checkOutput("t5 R locked opcode", dOpcode, 1);
            checkOutput("t5 R locked data", dData, 64'h500 + 64'(i));
            checkOutput("t5 b_ready held", axBReady, 0);
            @(posedge clk); @(negedge clk);
        end
        rId = 1; rData = 64'h600; rLast = 1;
        #1;
        checkOutput("t5 B wins opcode", dOpcode, 0);
        checkOutput("t5 B wins size", dSize, 5);
        checkOutput("t5 B wins source", dSource, 1);
        checkOutput("t5 r_ready held", rReady, 0);
        checkOutput("t5 b_ready", axBReady, 1);
        @(posedge clk); @(negedge clk);
        axBValid = 0;
        #1;
        checkOutput("t5 R after B opcode", dOpcode, 1);
        checkOutput("t5 R after B size", dSize, 3);
        checkOutput("t5 R after B data", dData, 64'h600);
        @(posedge clk); @(negedge clk);
        rValid = 0; rLast = 0;

        $display("[TB] reset in the middle of a put burst");
        applyStimulus("t6 put", OpPutFull, 4'd4, 1'b0, 56'h7000, 8'hFF, 64'h77);
        checkOutput("t6 aw_valid", awValid, 1);
        checkOutput("t6 w_last beat0", wLast, 0);
        aValid = 1; aOpcode = OpGet; aSize = 3;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6 rst aw_valid", awValid, 0);
        checkOutput("t6 rst w_valid", wValid, 0);
        checkOutput("t6 rst ar_valid", arValid, 0);
        checkOutput("t6 rst d_valid", dValid, 0);
        checkOutput("t6 rst a_ready", aReady, 0);
        aValid = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("t6 get", OpGet, 4'd2, 1'b1, 56'h6004, 8'h0F, 64'h0);
        checkOutput("t6 ar_valid", arValid, 1);
        checkOutput("t6 ar_addr", arAddr, 56'h6004);
        checkOutput("t6 ar_size", arSize, 2);
        checkOutput("t6 ar_len", arLen, 0);
        checkOutput("t6 ar_id", arId, 1);
        applyStimulus("t6 put", OpPutFull, 4'd3, 1'b0, 56'h8000, 8'hFF, 64'h88);
        checkOutput("t6 fresh aw_valid", awValid, 1);
        checkOutput("t6 fresh aw_addr", awAddr, 56'h8000);
        checkOutput("t6 fresh w_last", wLast, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
